// File: rtl/alu_pkg.sv
// Shared definitions for the APB ALU: opcodes, execution-stage state encoding
// and the default widths used by the CSR block, the FIFOs and the engine.
package alu_pkg;

    localparam int DEF_OPERATION_SIZE = 2;
    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_FIFO_IN_WIDTH  = DEF_OPERATION_SIZE + 2*DEF_DATA_WIDTH;
    localparam int DEF_FIFO_OUT_WIDTH = 2*DEF_DATA_WIDTH;

    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } exec_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// DATA_WIDTH cycles after start. The product is held until the next start.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] product
);

    localparam int CntWidth = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(DATA_WIDTH - 1);

    logic [2*DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
    logic [2*DATA_WIDTH-1:0] accStep;
    logic [CntWidth-1:0]     cnt_q, cnt_d;
    logic                    run_q, run_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

    // product is forwarded from the final step so the caller can latch it in the done cycle
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        accStep  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        done     = run_q && (cnt_q == CntLast);
        product  = done ? accStep : acc_q;

        if (start) begin
            mcand_d  = {{DATA_WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            acc_d    = accStep;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = done ? '0 : (cnt_q + CntWidth'(1));
            run_d    = !done;
        end
    end

endmodule

// File: rtl/alu_exec_engine.sv
// Execution stage of the APB ALU: pops one command from FIFO_IN, computes
// ADD in one cycle or MUL through alu_mul_seq, and pushes the result to FIFO_OUT.
module alu_exec_engine
    import alu_pkg::*;
#(
    parameter int OPERATION_SIZE = DEF_OPERATION_SIZE,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int FIFO_IN_WIDTH  = OPERATION_SIZE + 2*DATA_WIDTH,
    parameter int FIFO_OUT_WIDTH = 2*DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [FIFO_IN_WIDTH-1:0]  fifo_in_rdata,
    input  logic                      empty_in,
    output logic                      r_en_in,
    input  logic                      full_out,
    output logic                      w_en_out,
    output logic [FIFO_OUT_WIDTH-1:0] fifo_out_wdata,
    output logic                      busy,
    output logic                      op_err
);

    localparam logic [OPERATION_SIZE-1:0] OpAdd = OPERATION_SIZE'(OP_ADD);
    localparam logic [OPERATION_SIZE-1:0] OpMul = OPERATION_SIZE'(OP_MUL);

    exec_state_e state_q, state_d;

    logic [OPERATION_SIZE-1:0] op_q, op_d;
    logic [DATA_WIDTH-1:0]     a_q, a_d;
    logic [DATA_WIDTH-1:0]     b_q, b_d;
    logic [FIFO_OUT_WIDTH-1:0] result_q, result_d;

    logic [OPERATION_SIZE-1:0] cmdOp;
    logic [DATA_WIDTH-1:0]     cmdData0;
    logic [DATA_WIDTH-1:0]     cmdData1;
    logic [DATA_WIDTH:0]       addSum;
    logic                      mulStart;
    logic                      mulDone;
    logic [2*DATA_WIDTH-1:0]   mulProduct;

    assign cmdData0 = fifo_in_rdata[DATA_WIDTH-1:0];
    assign cmdData1 = fifo_in_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
    assign cmdOp    = fifo_in_rdata[FIFO_IN_WIDTH-1 -: OPERATION_SIZE];

    assign addSum         = {1'b0, a_q} + {1'b0, b_q};
    assign fifo_out_wdata = result_q;
    assign busy           = (state_q != IDLE);

    // The multiplier takes its operands straight from the FIFO word during LOAD
    // so that its DATA_WIDTH iterations line up exactly with the EXEC cycles.
    alu_mul_seq #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mulStart),
        .a       (cmdData0),
        .b       (cmdData1),
        .done    (mulDone),
        .product (mulProduct)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    // Unsupported opcodes still produce a zero word so results stay aligned with commands.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        r_en_in  = 1'b0;
        w_en_out = 1'b0;
        op_err   = 1'b0;
        mulStart = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!empty_in) begin
                    r_en_in = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                op_d     = cmdOp;
                a_d      = cmdData0;
                b_d      = cmdData1;
                mulStart = (cmdOp == OpMul);
                state_d  = EXEC;
            end
            EXEC: begin
                if (op_q == OpAdd) begin
                    result_d = FIFO_OUT_WIDTH'(addSum);
                    state_d  = WRITE;
                end else if (op_q == OpMul) begin
                    if (mulDone) begin
                        result_d = FIFO_OUT_WIDTH'(mulProduct);
                        state_d  = WRITE;
                    end
                end else begin
                    result_d = '0;
                    op_err   = 1'b1;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                if (!full_out) begin
                    w_en_out = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_exec_engine.sv
// Self-checking bench for alu_exec_engine: a FIFO_IN model feeds directed and
// random commands while a cycle-level reference predicts every output.
module tb_alu_exec_engine;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] d1;
        logic [15:0] d0;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [33:0] fifo_in_rdata = '0;
    logic        empty_in = 1'b1;
    logic        r_en_in;
    logic        full_out = 1'b0;
    logic        w_en_out;
    logic [31:0] fifo_out_wdata;
    logic        busy;
    logic        op_err;

    cmd_t        cmdQ[$];
    int          nChecks = 0;
    int          nErrs = 0;
    int          cyc = 0;
    bit          armed = 1'b0;
    bit          rstDrive = 1'b1;
    bit          randFull = 1'b0;
    int          stallLeft = 0;
    int          rstOffset = -1;
    bit          inflight = 1'b0;
    int          popCyc = 0;
    int          lat = 0;
    bit          curUnsup = 1'b0;
    logic [31:0] curRes = '0;
    logic [31:0] lastRes = '0;

    always #5 clk = ~clk;

    alu_exec_engine dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_in_rdata  (fifo_in_rdata),
        .empty_in       (empty_in),
        .r_en_in        (r_en_in),
        .full_out       (full_out),
        .w_en_out       (w_en_out),
        .fifo_out_wdata (fifo_out_wdata),
        .busy           (busy),
        .op_err         (op_err)
    );

    function automatic logic [31:0] refResult(cmd_t c);
        case (c.op)
            2'b01:   return 32'(c.d0) + 32'(c.d1);
            2'b10:   return 32'(c.d0) * 32'(c.d1);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [15:0] pickData();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nErrs++;
            $error("[TB] FAIL %s at cycle %0d: observed %h, expected %h", tag, cyc, observed, expected);
        end
    endtask

    task automatic applyStimulus(logic [1:0] op, logic [15:0] d1, logic [15:0] d0);
        cmdQ.push_back('{op: op, d1: d1, d0: d0});
    endtask

    // One clock: drive inputs at the falling edge, compare, then advance the reference.
    task automatic cycleStep();
        bit          wbEntry, expR, expW, expBusy, expErr, popped;
        logic [31:0] expData;
        logic [33:0] word;
        cmd_t        c;
        popped = 1'b0;
        word   = '0;
        @(negedge clk);
        empty_in = (cmdQ.size() == 0);
        wbEntry  = inflight && (cyc >= popCyc + lat);
        if (wbEntry && stallLeft > 0) begin
            full_out = 1'b1;
            stallLeft--;
        end else begin
            full_out = randFull ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        rst = rstDrive || (inflight && rstOffset >= 0 && cyc == popCyc + rstOffset);
        #1;
        expR    = !inflight && (cmdQ.size() != 0);
        expW    = wbEntry && !full_out;
        expBusy = inflight && (cyc > popCyc);
        expErr  = inflight && curUnsup && (cyc == popCyc + 2);
        expData = wbEntry ? curRes : lastRes;
        if (armed) begin
            checkOutput("r_en_in", 32'(r_en_in), 32'(expR));
            checkOutput("w_en_out", 32'(w_en_out), 32'(expW));
            checkOutput("busy", 32'(busy), 32'(expBusy));
            checkOutput("op_err", 32'(op_err), 32'(expErr));
            checkOutput("fifo_out_wdata", fifo_out_wdata, expData);
            checkOutput("pop_push_overlap", 32'(r_en_in & w_en_out), 32'd0);
        end
        if (expR) begin
            c        = cmdQ.pop_front();
            word     = {c.op, c.d1, c.d0};
            popped   = 1'b1;
            inflight = 1'b1;
            popCyc   = cyc;
            lat      = (c.op == 2'b10) ? 18 : 3;
            curUnsup = !(c.op == 2'b01 || c.op == 2'b10);
            curRes   = refResult(c);
        end
        if (expW) begin
            lastRes  = curRes;
            inflight = 1'b0;
        end
        if (rst) begin
            inflight  = 1'b0;
            lastRes   = '0;
            rstOffset = -1;
        end
        @(posedge clk);
        #1;
        fifo_in_rdata = popped ? word : {2'($urandom), 32'($urandom)};
        cyc++;
    endtask

    task automatic runUntilIdle();
        while (inflight || cmdQ.size() != 0) cycleStep();
        cycleStep();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cycleStep();
        cycleStep();
        rstDrive = 1'b0;
        armed    = 1'b1;
        cycleStep();

        $display("[TB] directed ADD");
        applyStimulus(2'b01, 16'h0003, 16'h0005);
        runUntilIdle();
        applyStimulus(2'b01, 16'hFFFF, 16'hFFFF);
        runUntilIdle();

        $display("[TB] directed MUL");
        applyStimulus(2'b10, 16'h1234, 16'h0010);
        runUntilIdle();
        applyStimulus(2'b10, 16'hFFFF, 16'hFFFF);
        runUntilIdle();

        $display("[TB] backpressure");
        stallLeft = 5;
        applyStimulus(2'b01, 16'h00A0, 16'h000B);
        runUntilIdle();
        stallLeft = 3;
        applyStimulus(2'b10, 16'h00FF, 16'h0101);
        runUntilIdle();

        $display("[TB] unsupported op");
        applyStimulus(2'b11, 16'h0001, 16'h0001);
        applyStimulus(2'b01, 16'h1111, 16'h2222);
        runUntilIdle();
        applyStimulus(2'b00, 16'hABCD, 16'h1234);
        runUntilIdle();

        $display("[TB] reset during MUL");
        rstOffset = 8;
        applyStimulus(2'b10, 16'h1234, 16'h5678);
        runUntilIdle();
        repeat (3) cycleStep();
        applyStimulus(2'b01, 16'h0007, 16'h0009);
        applyStimulus(2'b10, 16'h0003, 16'h0007);
        runUntilIdle();

        $display("[TB] back-to-back ADDs");
        applyStimulus(2'b01, 16'h0001, 16'h0002);
        applyStimulus(2'b01, 16'h8000, 16'h8000);
        applyStimulus(2'b01, 16'h00FF, 16'hFF01);
        runUntilIdle();

        $display("[TB] random commands");
        randFull = 1'b1;
        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
                applyStimulus(2'($urandom_range(0, 3)), pickData(), pickData());
            end
            runUntilIdle();
        end
        randFull = 1'b0;
        runUntilIdle();

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrs);
        $finish;
    end

endmodule

// File: doc/alu_exec_engine.md
# alu_exec_engine

Execution stage between FIFO_IN and FIFO_OUT of the APB ALU. It pops one command word {op, data1, data0} from FIFO_IN, computes the result, and pushes it into FIFO_OUT. The CSR block then returns that result on REG_RES reads. Add completes in one cycle. Multiply uses an iterative shift-add sequence of DATA_WIDTH cycles.

## Interface
Parameters:
- OPERATION_SIZE, 2, op field width (matches CSR ctrl_op)
- DATA_WIDTH, 16, operand width
- FIFO_IN_WIDTH, OPERATION_SIZE+2*DATA_WIDTH, command word width
- FIFO_OUT_WIDTH, 2*DATA_WIDTH, result word width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset: synchronous, active-high
- fifo_in_rdata  in  FIFO_IN_WIDTH  FIFO_IN head word; [DATA_WIDTH-1:0]=data0, next DATA_WIDTH=data1, MSBs=op
- empty_in  in  1  FIFO_IN empty
- r_en_in  out  1  FIFO_IN pop strobe
- full_out  in  1  FIFO_OUT full
- w_en_out  out  1  FIFO_OUT push strobe
- fifo_out_wdata  out  FIFO_OUT_WIDTH  result word
- busy  out  1  high in every state except IDLE
- op_err  out  1  one-cycle pulse when an unsupported op is consumed

## Operation
- Opcodes: 2'b01 = ADD, 2'b10 = MUL. Any other code is unsupported.
- FSM states: IDLE, LOAD, EXEC, WRITE.
- IDLE:
  - When empty_in=0, r_en_in=1 (combinational, this cycle only) and next state is LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - FIFO_IN read data is valid one cycle after r_en_in. Register op, a=data0, b=data1. Go to EXEC.
- EXEC, ADD: result = zero-extend(a+b). The carry lands in bit DATA_WIDTH; upper bits are 0. One cycle, then WRITE.
- EXEC, MUL:
  - Unsigned shift-add. Counter runs from 0 to DATA_WIDTH-1.
  - Each cycle: if multiplier LSB = 1, acc += multiplicand. Then multiplicand <<= 1 and multiplier >>= 1.
  - Counter wraps at DATA_WIDTH-1 and moves to WRITE. Result is the exact 2*DATA_WIDTH-bit product.
- EXEC, unsupported op: result = 0, op_err=1 for that cycle, then WRITE. A word is always produced, so read ordering stays aligned with commands.
- WRITE:
  - If full_out=0: w_en_out=1 (one cycle), fifo_out_wdata=result, go to IDLE.
  - If full_out=1: hold result, keep w_en_out=0, stay in WRITE indefinitely.
- No new pop while a command is in flight; at most one command is in flight.
- fifo_out_wdata is a registered result and stays stable outside WRITE.

## Timing
- Reset values: state=IDLE, r_en_in=0, w_en_out=0, fifo_out_wdata=0, busy=0, op_err=0; counter and all operand/accumulator registers = 0.
- Reset asserted mid-command: the command is discarded, nothing is pushed, and the engine is in IDLE on the next edge. A FIFO_IN entry already popped is lost. This is allowed.
- Latency, with r_en_in high at cycle T and full_out=0:
  - ADD or unsupported op: w_en_out at T+3.
  - MUL: w_en_out at T+2+DATA_WIDTH (T+18 with defaults).
- Each cycle full_out stays high during WRITE adds one cycle of latency.
- Back-to-back throughput: the next r_en_in comes no earlier than the cycle after w_en_out.
  - ADD: one command per 4 cycles.
  - MUL: one command per DATA_WIDTH+3 cycles.
- r_en_in and w_en_out are never high in the same cycle.
- empty_in is sampled only in IDLE; full_out is sampled only in WRITE.
- A pop and the CSR's push to FIFO_IN in the same cycle are handled by the FIFO; this block places no constraint on that.

## Structure
- Shared package alu_pkg holds:
  - OP_ADD=2'b01, OP_MUL=2'b10.
  - State encoding IDLE/LOAD/EXEC/WRITE.
  - Default width constants, also used by the CSR and the FIFOs.
- Sub-module alu_mul_seq:
  - Iterative unsigned shift-add multiplier.
  - Ports: clk, rst, start, a, b, done, product.
  - done pulses in the last EXEC cycle; product is held until the next start.
- The FSM, ADD datapath and result register stay in alu_exec_engine.
- Registers use the codebase's d_ff enable cells or equivalent always blocks with synchronous reset.

## Test plan
- ADD: push {01, 16'h0003, 16'h0005}, empty_in falls -> r_en_in at T, w_en_out at T+3 with fifo_out_wdata=32'h0000_0008. Push {01, FFFF, FFFF} -> 32'h0001_FFFE.
- MUL: {10, 16'h1234, 16'h0010} -> w_en_out at T+18 with 32'h0001_2340. {10, FFFF, FFFF} -> 32'hFFFE_0001.
- Backpressure: hold full_out=1 at WRITE entry for 5 cycles -> w_en_out stays 0 and busy stays 1; release -> a single w_en_out pulse with the correct value, then back to IDLE.
- Unsupported op: {11, 1, 1} -> op_err pulses once in EXEC and w_en_out pushes 32'h0 at T+3. The next valid command is unaffected.
- Reset mid-MUL: assert rst at T+8 for one cycle -> no w_en_out; all outputs at reset values the next cycle. A following ADD completes normally.
- Back-to-back: three queued ADDs -> r_en_in at T, T+4 and T+8; results pushed in order; r_en_in and w_en_out never high together.
